// File: rtl/alex_spi_multi.sv
// Multi-channel serial loader for Alex filter/relay boards: one shared data/clock pair,
// one latch strobe per channel, automatic resend on change, force request and reset release.
module alex_spi_multi #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned REPEAT     = 2,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                         spi_clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         force_req,  // resend-all request ("force" is reserved)
    input  logic [NUM_CH*DATA_WIDTH-1:0] Alex_data,
    output logic                         SPI_data,
    output logic                         SPI_clock,
    output logic [NUM_CH-1:0]            load_strobe,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SumW = ChW + 1;
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [1:0]      RepLast = 2'(REPEAT - 1);
    localparam logic [ChW-1:0]  ChLast  = ChW'(NUM_CH - 1);
    localparam logic [SumW-1:0] ChNum   = SumW'(NUM_CH);

    typedef enum logic [2:0] {
        StIdle,
        StShiftLo,
        StShiftHi,
        StStrobe,
        StGap,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ChW-1:0]        sel_q, sel_d;
    logic [ChW-1:0]        rr_q, rr_d;
    logic [DATA_WIDTH-1:0] snap_q, snap_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [1:0]            rep_q, rep_d;
    logic [DivW-1:0]       div_q, div_d;
    logic [NUM_CH-1:0]     pending_q, pending_d;
    logic [DATA_WIDTH-1:0] prev_q [NUM_CH];
    logic [DATA_WIDTH-1:0] prev_d [NUM_CH];
    logic [DATA_WIDTH-1:0] chan   [NUM_CH];

    logic [ChW-1:0]        pick;
    logic                  pick_vld;
    logic [SumW-1:0]       sum;
    logic                  start;
    logic                  div_last;
    logic [NUM_CH-1:0]     active;
    logic [NUM_CH-1:0]     changed;
    logic [BitW-1:0]       bit_idx;
    logic                  spi_data_d;
    logic                  spi_clock_d;
    logic [NUM_CH-1:0]     strobe_d;
    logic                  busy_d;
    logic                  frame_done_d;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            chan[c] = Alex_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin pick: first pending channel at or after rr_q, wrapping.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = SumW'(rr_q) + SumW'(i);
            if (sum >= ChNum) begin
                sum = sum - ChNum;
            end
            if (!pick_vld && pending_q[sum[ChW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = sum[ChW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        snap_d   = snap_q;
        bit_d    = bit_q;
        rep_d    = rep_q;
        div_d    = div_q;
        prev_d   = prev_q;
        start    = 1'b0;
        div_last = (div_q == DivLast);

        case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    start = 1'b1;
                    sel_d = pick;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (pick == ChW'(c)) begin
                            snap_d = chan[c];
                        end
                    end
                    bit_d   = BitLast;
                    rep_d   = '0;
                    div_d   = '0;
                    state_d = StShiftLo;
                end
            end
            StShiftLo: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = StShiftHi;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StShiftHi: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == '0) begin
                        state_d = StStrobe;
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        state_d = StShiftLo;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StStrobe: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = StGap;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StGap: begin
                if (rep_q < RepLast) begin
                    rep_d   = rep_q + 1'b1;
                    bit_d   = BitLast;
                    state_d = StShiftLo;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (sel_q == ChW'(c)) begin
                        prev_d[c] = snap_q;
                    end
                end
                rr_d    = (sel_q == ChLast) ? '0 : sel_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // The channel in flight compares against a stale prev until DONE, so its change
        // detection is masked; prev then takes the snapshot and later edits are seen in IDLE.
        active  = '0;
        changed = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if ((state_q != StIdle && sel_q == ChW'(c)) || (start && pick == ChW'(c))) begin
                active[c] = 1'b1;
            end
            changed[c] = enable && (chan[c] != prev_q[c]) && !active[c];
        end

        pending_d = pending_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (start && pick == ChW'(c)) begin
                pending_d[c] = 1'b0;
            end
        end
        pending_d = pending_d | changed;
        if (force_req) begin
            pending_d = '1;
        end

        // Pin values are registered from next-state so the connector sees glitch-free levels.
        bit_idx      = MSB_FIRST ? bit_d : BitLast - bit_d;
        spi_data_d   = ((state_d == StShiftLo) || (state_d == StShiftHi)) && snap_d[bit_idx];
        spi_clock_d  = (state_d == StShiftHi);
        strobe_d     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (state_d == StStrobe && sel_d == ChW'(c)) begin
                strobe_d[c] = 1'b1;
            end
        end
        busy_d       = (state_d != StIdle);
        frame_done_d = (state_d == StDone);
    end

    always_ff @(posedge spi_clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            rr_q        <= '0;
            snap_q      <= '0;
            bit_q       <= '0;
            rep_q       <= '0;
            div_q       <= '0;
            pending_q   <= '1;
            for (int c = 0; c < NUM_CH; c++) begin
                prev_q[c] <= '0;
            end
            SPI_data    <= 1'b0;
            SPI_clock   <= 1'b0;
            load_strobe <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_q        <= rr_d;
            snap_q      <= snap_d;
            bit_q       <= bit_d;
            rep_q       <= rep_d;
            div_q       <= div_d;
            pending_q   <= pending_d;
            for (int c = 0; c < NUM_CH; c++) begin
                prev_q[c] <= prev_d[c];
            end
            SPI_data    <= spi_data_d;
            SPI_clock   <= spi_clock_d;
            load_strobe <= strobe_d;
            busy        <= busy_d;
            frame_done  <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_alex_spi_multi.sv
// Directed bench for alex_spi_multi: default instance plus a CLK_DIV=3, LSB-first, single-repeat one.
module tb_alex_spi_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, force_req;
    logic [63:0] alex_data;
    logic        spi_data, spi_sck, busy, frame_done;
    logic [1:0]  load_strobe;

    logic        rst2;
    logic [63:0] alex_data2;
    logic        spi_data2, spi_sck2, busy2, frame_done2;
    logic [1:0]  load_strobe2;

    alex_spi_multi dut (
        .spi_clock   (clk),
        .reset       (rst),
        .enable      (enable),
        .force_req   (force_req),
        .Alex_data   (alex_data),
        .SPI_data    (spi_data),
        .SPI_clock   (spi_sck),
        .load_strobe (load_strobe),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    alex_spi_multi #(
        .CLK_DIV   (3),
        .REPEAT    (1),
        .MSB_FIRST (1'b0)
    ) dut2 (
        .spi_clock   (clk),
        .reset       (rst2),
        .enable      (1'b0),
        .force_req   (1'b0),
        .Alex_data   (alex_data2),
        .SPI_data    (spi_data2),
        .SPI_clock   (spi_sck2),
        .load_strobe (load_strobe2),
        .busy        (busy2),
        .frame_done  (frame_done2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the default instance: strobe events carry the last 32 sampled bits.
    typedef struct {
        int          ch;
        logic [31:0] word;
        int          nbits;
    } ev_t;

    ev_t         evq[$];
    ev_t         ev;
    int          len_q[$];
    int          cyc = 0, nbits = 0, edges = 0, done_cnt = 0, rise_cyc = 0;
    logic [31:0] acc = '0;
    logic        sck_p = 0, busy_p = 0, fd_p = 0;
    logic [1:0]  ls_p = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            nbits  = 0;
            sck_p  = 0;
            busy_p = 0;
            fd_p   = 0;
            ls_p   = '0;
        end else begin
            if (spi_sck && !sck_p) begin
                acc = {acc[30:0], spi_data};
                nbits++;
                edges++;
            end
            for (int c = 0; c < 2; c++) begin
                if (load_strobe[c] && !ls_p[c]) begin
                    ev.ch    = c;
                    ev.word  = acc;
                    ev.nbits = nbits;
                    evq.push_back(ev);
                    nbits = 0;
                end
            end
            if (busy && !busy_p) rise_cyc = cyc;
            if (frame_done && !fd_p) begin
                done_cnt++;
                len_q.push_back(cyc - rise_cyc);
            end
            sck_p  = spi_sck;
            busy_p = busy;
            fd_p   = frame_done;
            ls_p   = load_strobe;
        end
    end

    // Monitor for the slow LSB-first instance (first frame only).
    int          cyc2 = 0, e2 = 0, r1 = 0, r2 = 0, stb_w = 0, rise2 = -1, done2 = -1;
    int          nb2 = 0, nbcap = 0;
    logic        b1 = 0, b2 = 0;
    logic [31:0] acc2 = '0, word2 = '0;
    logic        sck2_p = 0, ls2_p = 0, busy2_p = 0, fd2_p = 0;

    always @(negedge clk) begin
        cyc2++;
        if (!rst2) begin
            if (spi_sck2 && !sck2_p) begin
                e2++;
                if (e2 == 1) begin r1 = cyc2; b1 = spi_data2; end
                if (e2 == 2) begin r2 = cyc2; b2 = spi_data2; end
                acc2 = {spi_data2, acc2[31:1]};
                nb2++;
            end
            if (load_strobe2[0]) stb_w++;
            if (load_strobe2[0] && !ls2_p) begin
                word2 = acc2;
                nbcap = nb2;
            end
            if (busy2 && !busy2_p && rise2 < 0) rise2 = cyc2;
            if (frame_done2 && !fd2_p && done2 < 0) done2 = cyc2;
            sck2_p  = spi_sck2;
            ls2_p   = load_strobe2[0];
            busy2_p = busy2;
            fd2_p   = frame_done2;
        end
    end

    task automatic clear_mon();
        evq.delete();
        len_q.delete();
        edges    = 0;
        done_cnt = 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_edges(input int n, input string name);
        for (int k = 0; k < 300 && edges < n; k++) @(negedge clk);
        check(name, edges >= n, 1'b1);
    endtask

    // Expected strobe events: each channel update yields two identical strobe events.
    task automatic check_events(input string name, input int n, input int c0, input logic [31:0] w0,
                                input int c1, input logic [31:0] w1);
        check({name, " strobes"}, evq.size(), 2 * n);
        for (int j = 0; j < evq.size() && j < 2 * n; j++) begin
            check($sformatf("%s ev%0d ch", name, j), evq[j].ch, (j < 2) ? c0 : c1);
            check($sformatf("%s ev%0d word", name, j), evq[j].word, (j < 2) ? w0 : w1);
            check($sformatf("%s ev%0d bits", name, j), evq[j].nbits, 32);
        end
    endtask

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        en;
        logic        frc;
        int          n;
        int          c0;
        logic [31:0] w0;
        int          c1;
        logic [31:0] w1;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] d0, input logic [31:0] d1, input logic en,
                                input logic frc, input int n, input int c0, input logic [31:0] w0,
                                input int c1, input logic [31:0] w1);
        vec_t v;
        v.d0 = d0; v.d1 = d1; v.en = en; v.frc = frc; v.n = n;
        v.c0 = c0; v.w0 = w0; v.c1 = c1; v.w1 = w1;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = mk(32'hA5A5_0F0F, 32'h0,         1, 0, 1, 0, 32'hA5A5_0F0F, 0, 32'h0);
        vecs[1] = mk(32'hA5A5_0F0F, 32'h0000_0001, 0, 0, 0, 0, 32'h0,         0, 32'h0);
        vecs[2] = mk(32'hA5A5_0F0F, 32'h0000_0001, 1, 0, 1, 1, 32'h0000_0001, 0, 32'h0);
        vecs[3] = mk(32'hA5A5_0F0F, 32'h0000_0001, 1, 1, 2, 0, 32'hA5A5_0F0F, 1, 32'h0000_0001);
        vecs[4] = mk(32'h1234_5678, 32'hFFFF_0000, 1, 0, 2, 0, 32'h1234_5678, 1, 32'hFFFF_0000);
        vecs[5] = mk(32'h1234_5678, 32'h8000_0001, 1, 1, 2, 0, 32'h1234_5678, 1, 32'h8000_0001);
        vecs[6] = mk(32'hDEAD_BEEF, 32'h8000_0001, 1, 0, 1, 0, 32'hDEAD_BEEF, 0, 32'h0);
        vecs[7] = mk(32'hDEAD_BEEF, 32'h8000_0001, 1, 0, 0, 0, 32'h0,         0, 32'h0);

        rst        = 1'b1;
        rst2       = 1'b1;
        enable     = 1'b0;
        force_req  = 1'b0;
        alex_data  = '0;
        alex_data2 = {32'h0, 32'h0000_0003};
        wait_cyc(3);

        check("reset SPI_data", spi_data, 0);
        check("reset SPI_clock", spi_sck, 0);
        check("reset load_strobe", load_strobe, 0);
        check("reset busy", busy, 0);
        check("reset frame_done", frame_done, 0);

        // Power-up resync: both zero words are sent twice each.
        clear_mon();
        rst = 1'b0;
        wait_cyc(300);
        check_events("resync", 2, 0, 32'h0, 1, 32'h0);
        check("resync edges", edges, 128);
        check("resync done", done_cnt, 2);
        check("resync len0", (len_q.size() > 0) ? len_q[0] : -1, 132);
        check("resync len1", (len_q.size() > 1) ? len_q[1] : -1, 132);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            alex_data = {vecs[i].d1, vecs[i].d0};
            enable    = vecs[i].en;
            force_req = vecs[i].frc;
            clear_mon();
            @(negedge clk);
            force_req = 1'b0;
            wait_cyc(vecs[i].n * 140 + 30);
            check_events($sformatf("vec%0d", i), vecs[i].n, vecs[i].c0, vecs[i].w0,
                         vecs[i].c1, vecs[i].w1);
            check($sformatf("vec%0d done", i), done_cnt, vecs[i].n);
            check($sformatf("vec%0d edges", i), edges, vecs[i].n * 64);
        end

        // Change during a frame: old snapshot completes, newest value follows.
        @(negedge clk);
        alex_data[31:0] = 32'h0F0F_0000;
        clear_mon();
        wait_edges(10, "midchg reach");
        alex_data[31:0] = 32'h1;
        @(negedge clk);
        alex_data[31:0] = 32'h2;
        wait_cyc(400);
        check_events("midchg", 2, 0, 32'h0F0F_0000, 0, 32'h2);
        check("midchg done", done_cnt, 2);

        // Change that reverts to the in-flight snapshot before DONE: no resend.
        @(negedge clk);
        alex_data[31:0] = 32'h55;
        clear_mon();
        wait_edges(10, "revert reach");
        alex_data[31:0] = 32'h77;
        @(negedge clk);
        alex_data[31:0] = 32'h55;
        wait_cyc(400);
        check_events("revert", 1, 0, 32'h55, 0, 32'h0);
        check("revert done", done_cnt, 1);

        // Reset with SPI_clock high mid-word.
        @(negedge clk);
        alex_data[31:0] = 32'hFFFF_FFFF;
        clear_mon();
        for (int k = 0; k < 300 && !(edges >= 5 && spi_sck); k++) @(negedge clk);
        check("rstmid reach", edges >= 5 && spi_sck, 1'b1);
        check("rstmid data before", spi_data, 1);
        #1 rst = 1'b1;
        #1;
        check("rstmid SPI_clock", spi_sck, 0);
        check("rstmid SPI_data", spi_data, 0);
        check("rstmid strobe", load_strobe, 0);
        check("rstmid busy", busy, 0);
        check("rstmid no strobe event", evq.size(), 0);
        wait_cyc(2);
        clear_mon();
        rst = 1'b0;
        wait_cyc(300);
        check_events("rstmid resync", 2, 0, 32'hFFFF_FFFF, 1, 32'h8000_0001);

        // Slow LSB-first single-repeat instance.
        @(negedge clk);
        rst2 = 1'b0;
        wait_cyc(450);
        check("div3 bit period", r2 - r1, 6);
        check("div3 bit0", b1, 1);
        check("div3 bit1", b2, 1);
        check("div3 strobe width", stb_w, 3);
        check("div3 frame len", done2 - rise2, 196);
        check("div3 word", word2, 32'h0000_0003);
        check("div3 bits", nbcap, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alex_spi_multi.md
Name: alex_spi_multi

Overview:
Parametrised serial loader for Alex filter/relay boards. It drives NUM_CH independent shift-register targets over one shared serial data/clock pair, with one load strobe per target. Each channel's word is resent automatically whenever it changes, on a software force request, and after reset. It sits between the protocol/register decode logic and the Alex connector pins, and supersedes the single-word 32-bit loader.

Parameters:
DATA_WIDTH, 32, bits per channel word
NUM_CH, 2, number of target channels (each has its own load strobe), 1..8
CLK_DIV, 1, SPI_clock half-period in spi_clock cycles, >=1
REPEAT, 2, number of times each word is transmitted per update, 1..4
MSB_FIRST, 1, 1 = shift bit DATA_WIDTH-1 first; 0 = shift bit 0 first

Ports:
spi_clock  in  1  sole clock; all logic runs on the rising edge
reset  in  1  asynchronous, active-high
enable  in  1  when high, a word change on any channel marks that channel pending
force  in  1  single-cycle request; marks all channels pending
Alex_data  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
SPI_data  out  1  serial data
SPI_clock  out  1  serial clock; idles low
load_strobe  out  NUM_CH  per-channel latch strobe, active-high
busy  out  1  high from frame start until return to IDLE
frame_done  out  1  one-cycle pulse after the last repeat of a channel completes

Behaviour:
- Reset (asynchronous): SPI_data=0, SPI_clock=0, load_strobe=0, busy=0, frame_done=0, all prev[c]=0, pending=all ones, state=IDLE, round-robin pointer=0.
- Channels are sent even after reset when their data equals zero (power-up resync).
- Pending set per cycle for channel c when any of these holds:
  - enable=1 and Alex_data[c] != prev[c], or
  - force=1, or
  - the reset release described above.
  Pending bits set during a frame are held, not lost.
- States: IDLE, SHIFT_LO, SHIFT_HI, STROBE, GAP, DONE.
- IDLE: if any pending, select the first pending channel at or after the rr pointer (wrapping). Then:
  - snapshot Alex_data[sel] into shift_reg;
  - clear pending[sel];
  - set bit_cnt=DATA_WIDTH-1 and rep_cnt=0;
  - busy=1; go to SHIFT_LO.
  Next cycle, SPI_data carries the first bit.
- SHIFT_LO: SPI_clock=0 and SPI_data=current bit, held for CLK_DIV cycles; then go to SHIFT_HI.
- SHIFT_HI: SPI_clock=1 for CLK_DIV cycles. Data is stable across the rising edge. Then:
  - if bit_cnt=0, go to STROBE;
  - else decrement bit_cnt, advance to the next bit (per MSB_FIRST), and go to SHIFT_LO.
- STROBE: SPI_clock=0, load_strobe[sel]=1 for CLK_DIV cycles; other strobe bits stay 0. Then go to GAP.
- GAP: one cycle with all outputs low. Then:
  - if rep_cnt<REPEAT-1, increment rep_cnt, reload bit_cnt, resend the same snapshot (SHIFT_LO);
  - else go to DONE.
- DONE: one cycle. frame_done=1; prev[sel]<=snapshot; rr pointer=sel+1 mod NUM_CH; busy=0; go to IDLE.
- Per-channel cycle count from IDLE select to frame_done = 1 + REPEAT*(2*CLK_DIV*DATA_WIDTH + CLK_DIV + 1).
- Data changing during a frame: the snapshot is transmitted unchanged. Because prev takes the snapshot, the newer value is detected and resent afterwards.
- If the data reverts to prev before that frame's DONE, no resend occurs.
- enable=0: changes are ignored while low. They are detected as soon as enable rises, provided data still differs from prev.
- force and a change on the same cycle: a single pending bit results, so the channel is sent once.
- Reset mid-frame: outputs drop immediately. No partial strobe is issued after release. The reset release re-marks all channels pending.
- The bit counter width is clog2(DATA_WIDTH). The counter never wraps below 0.

Test Plan:
1. Defaults, Alex_data=0, release reset: 64 SPI_clock rising edges of 0, then 2 load_strobe[0] pulses, then 64 more with 2 load_strobe[1] pulses. frame_done pulses twice; each channel takes 133 cycles.
2. enable=1, set ch0 to 32'hA5A5_0F0F: bits sampled on rising edges are 1010_0101_1010_0101_0000_1111_0000_1111, twice. load_strobe[0] pulses twice; load_strobe[1] never pulses.
3. enable=0, change ch1 to 32'h0000_0001: no activity. Raise enable: ch1 is sent twice, with the last bit=1 and only load_strobe[1] pulsing.
4. Change ch0 to 32'h1 at the 10th rising edge of its frame, then to 32'h2: the current frame completes with the old word. A second frame follows carrying 32'h2.
5. Assert reset at mid-bit (SPI_clock=1): SPI_clock and SPI_data go low the same cycle with no strobe. After release, both channels are resent.
6. CLK_DIV=3, MSB_FIRST=0, REPEAT=1, ch0=32'h0000_0003: bit period is 6 cycles, the first two bits are 1, the strobe is 3 cycles wide, and frame_done occurs 1+196=197 cycles after the IDLE select.
